// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the regfile writeback arbiter: bus widths, request record, zero-register index.
package regfile_wb_arbiter_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef logic [ADDRESS_WIDTH-1:0] ADDR_BUS;
    typedef logic [DATA_WIDTH-1:0]    DATA_BUS;

    typedef struct packed {
        logic    valid;
        ADDR_BUS addr;
        DATA_BUS data;
    } wb_req_t;

    // x0 is hard-wired to zero in the register file; writes to it are dropped.
    localparam ADDR_BUS REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ sources presenting valid/addr/data, arbiter returning ready.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import regfile_wb_arbiter_pkg::*;

    // Handshake: a transfer from source i happens on the rising edge where
    // req_valid[i] & req_ready[i]; a source holds valid/addr/data stable until then,
    // and ready is never raised toward a source whose valid is low.
    logic [NUM_REQ-1:0] req_valid;
    ADDR_BUS            req_addr [NUM_REQ];
    DATA_BUS            req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port (WE3/AD3/WD3) among NUM_REQ writeback sources.
// Optional feature: define CONFLICT_CNT_EN to add the saturating conflict_count output.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
`ifdef CONFLICT_CNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_hold,
    regfile_wb_arbiter_if.slave        wb,
    output logic                       rf_we3,
    output ADDR_BUS                    rf_ad3,
    output DATA_BUS                    rf_wd3
`ifdef CONFLICT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]       conflict_count
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               transfer;
    wb_req_t            sel_req;

    rr_arbiter #(.N(NUM_REQ), .IW(PW)) u_rr (
        .req       (wb.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Reset and hold both suppress the grant combinationally so no source sees a phantom transfer.
    assign wb.req_ready = (rst || wb_hold) ? '0 : grant;
    assign transfer     = |wb.req_ready;

    always_comb begin
        sel_req.valid = wb.req_valid[grant_idx];
        sel_req.addr  = wb.req_addr[grant_idx];
        sel_req.data  = wb.req_data[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            rf_we3 <= 1'b0;
            rf_ad3 <= '0;
            rf_wd3 <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
            rf_ad3 <= sel_req.addr;
            rf_wd3 <= sel_req.data;
            // An x0 destination still completes the handshake but never reaches the regfile.
            rf_we3 <= sel_req.valid && (sel_req.addr != REG_ZERO);
        end else begin
            rf_we3 <= 1'b0;
        end
    end

`ifdef CONFLICT_CNT_EN
    // Counts contention cycles independent of wb_hold; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_count <= '0;
        end else if (($countones(wb.req_valid) >= 2) && (conflict_count != '1)) begin
            conflict_count <= conflict_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int CW = 16;

    logic    clk = 1'b0;
    logic    rst;
    logic    wb_hold;
    logic    rf_we3;
    ADDR_BUS rf_ad3;
    DATA_BUS rf_wd3;
`ifdef CONFLICT_CNT_EN
    logic [CW-1:0] conflict_count;
`endif

    regfile_wb_arbiter_if #(.NUM_REQ(N)) wb ();

    regfile_wb_arbiter #(
        .NUM_REQ   (N)
`ifdef CONFLICT_CNT_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_hold        (wb_hold),
        .wb             (wb),
        .rf_we3         (rf_we3),
        .rf_ad3         (rf_ad3),
        .rf_wd3         (rf_wd3)
`ifdef CONFLICT_CNT_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    int      n_checks = 0;
    int      n_errors = 0;
    int      m_ptr;
    logic    m_we;
    ADDR_BUS m_ad;
    DATA_BUS m_wd;
    int      m_cnt;
    int      m_last_g;
    logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin choice: lowest valid index at or above ptr, otherwise lowest valid overall.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = ptr; i < N; i++) if (v[i]) return i;
        for (int i = 0; i < ptr; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input ADDR_BUS a, input DATA_BUS d);
        wb.req_valid[i] = v;
        wb.req_addr[i]  = a;
        wb.req_data[i]  = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the rising edge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_ready;
        logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] w;
        @(negedge clk);
        g = (rst || wb_hold) ? -1 : pick(wb.req_valid, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("req_ready", 64'(wb.req_ready), 64'(exp_ready));
        check_val("rf_we3", 64'(rf_we3), 64'(m_we));
        if (m_we && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_val("rf_ad3_write", 64'(rf_ad3), 64'(w[ADDRESS_WIDTH+DATA_WIDTH-1:DATA_WIDTH]));
            check_val("rf_wd3_write", 64'(rf_wd3), 64'(w[DATA_WIDTH-1:0]));
        end else begin
            check_val("rf_ad3_held", 64'(rf_ad3), 64'(m_ad));
            check_val("rf_wd3_held", 64'(rf_wd3), 64'(m_wd));
        end
`ifdef CONFLICT_CNT_EN
        check_val("conflict_count", 64'(conflict_count), 64'(m_cnt));
`endif
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_ad = '0; m_wd = '0; m_cnt = 0; m_last_g = -1;
            exp_q.delete();
        end else begin
            if ($countones(wb.req_valid) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (g >= 0) begin
                m_ad = wb.req_addr[g];
                m_wd = wb.req_data[g];
                m_we = (wb.req_addr[g] != 0);
                if (m_we) exp_q.push_back({m_ad, m_wd});
                m_ptr = (g + 1) % N;
                m_last_g = g;
            end else begin
                m_we = 1'b0;
                m_last_g = -1;
            end
        end
        #1;
    endtask

    initial begin
        m_ptr = 0; m_we = 1'b0; m_ad = '0; m_wd = '0; m_cnt = 0; m_last_g = -1;
        rst = 1'b1;
        wb_hold = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, ADDR_BUS'(i + 1), $urandom);
        @(posedge clk);
        #1;

        // reset with all sources valid
        repeat (3) cycle();
        rst = 1'b0;

        // single request, latency one
        clear_reqs();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        clear_reqs();
        cycle();
        cycle();

        // contention straight out of reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        repeat (4) cycle();

        // x0 destination is acknowledged but dropped
        clear_reqs();
        set_req(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        cycle();
        clear_reqs();
        set_req(0, 1'b1, 5'd3, 32'h33);
        set_req(1, 1'b1, 5'd4, 32'h44);
        repeat (2) cycle();

        // hold freezes grants and pointer
        wb_hold = 1'b1;
        repeat (4) cycle();
        wb_hold = 1'b0;
        repeat (2) cycle();

        // reset right after a transfer discards the staged write
        clear_reqs();
        set_req(0, 1'b1, 5'd7, 32'h77);
        cycle();
        clear_reqs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 5'd8, 32'h88);
        set_req(1, 1'b1, 5'd9, 32'h99);
        repeat (2) cycle();
        clear_reqs();

        // randomized traffic; sources hold their request until granted
        for (int c = 0; c < 400; c++) begin
            wb_hold = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_last_g == i) wb.req_valid[i] = 1'b0;
                if (!wb.req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'b1,
                            ($urandom_range(0, 3) == 0) ? ADDR_BUS'(0) : ADDR_BUS'($urandom_range(1, 31)),
                            $urandom);
            end
            cycle();
        end
        rst = 1'b0;
        wb_hold = 1'b0;
        clear_reqs();
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
